dma_fifo_reader: RTL

DMA_FIFO_READER -- requirements
Module: dma_fifo_reader

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_fifo_reader.sv | 106 ++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA FIFO-to-memory reader, its FIFO and the bench.
package dma_pkg;

    localparam int unsigned DMA_WIDTH  = 32;
    localparam int unsigned DMA_ADDR_W = 16;
    localparam int unsigned DMA_LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_fifo_reader.sv
// Drains len_words words from a FIFO and writes them to consecutive memory addresses,
// one word at a time through a single holding register.
module dma_fifo_reader
    import dma_pkg::*;
#(
    parameter int unsigned WIDTH  = DMA_WIDTH,
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_rdata,
    input  logic              fifo_empty,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ready
);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [WIDTH-1:0]  hold_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_valid_q;

    // Transfer FSM; status outputs are registered alongside the state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= len_words;
                        if (len_words == '0) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    hold_q      <= fifo_rdata;
                    mem_valid_q <= 1'b1;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Hold address and data until the memory takes the word.
                    if (mem_ready) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        mem_valid_q <= 1'b0;
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read request is only raised in FETCH and never against an empty FIFO.
    assign fifo_rd_en = (state_q == ST_FETCH) && !fifo_empty;

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = hold_q;

endmodule
